gf2m409_pp_accum_reduce: RTL
============================

Name: gf2m409_pp_accum_reduce

Overview:
Downstream consumer of the 103-bit overlap-free Karatsuba multiplier in the GF(2^409) datapath.
- Operands are split into four 103-bit digits (412 bits, top 3 bits zero).
- Accepts the 16 digit-pair products (205 bits each) over a valid/ready stream.
- XOR-accumulates each product at offset 103*(i+j), then reduces modulo f(x)=x^409+x^87+1 in two fixed fold cycles.
- Presents the 409-bit field product on a valid/ready output.

Parameters:
M, 409, field degree
D, 103, digit width (input product width 2*D-1)
ND, 4, digits per operand
K, 87, middle-term exponent of f(x)
ACC_W, 823, accumulator width (2*(ND-1)*D + 2*D-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pp_valid  in  1  partial product present
pp_ready  out  1  block can accept a partial product
pp_data  in  2*D-1  carry-less digit product (multiplier y output)
pp_idx_i  in  2  digit index of operand a
pp_idx_j  in  2  digit index of operand b
pp_last  in  1  final partial product of this multiplication
res_valid  out  1  reduced result available
res_ready  in  1  consumer accepts result
res_data  out  M  reduced product, bit k = coeff of x^k
busy  out  1  state != ACCUM or accumulator non-empty
pp_dup_err  out  1  sticky: same (i,j) accepted twice in one multiplication

Behaviour:
- Reset (async, rst_n=0): state=ACCUM, acc=0, seen mask (16 bits)=0, res_valid=0, res_data=0, pp_dup_err=0, busy=0, pp_ready=1 after release.
- States: ACCUM -> FOLD1 -> FOLD2 -> OUT -> ACCUM.
- ACCUM:
  - pp_ready=1; accept on pp_valid&pp_ready.
  - acc ^= pp_data << (D*(i+j)).
  - Set seen[4*i+j]; if already set, assert pp_dup_err (still accumulate).
  - If pp_last accepted: go to FOLD1. The last product is included.
- FOLD1: hi=acc[ACC_W-1:M]; acc <= acc[M-1:0] ^ hi ^ (hi<<K), zero-extended. pp_ready=0.
- FOLD2: same fold on the remaining hi (max 92 bits); the result has degree < 409. res_data <= acc result[M-1:0]; go to OUT.
- OUT:
  - res_valid=1; res_data held stable while res_ready=0.
  - On res_ready: res_valid=0, acc=0, seen=0, state=ACCUM.
  - pp_ready=0 throughout OUT.
- Latency: last product accepted at edge t; res_valid high from edge t+3. Throughput: one product per cycle in ACCUM.
- Missing (i,j) pairs are treated as zero; no error.
- pp_last on the very first product is legal (single-product multiply).
- pp_valid outside ACCUM is ignored (not accepted, no state change).
- pp_dup_err clears only on reset.
- Reset mid-operation: all state is discarded, including a pending result.
- All arithmetic is GF(2): XOR only, no carries.

Decomposition:
- Shared package gf2m409_pkg: M, D, ND, K, ACC_W constants; state enum {ACCUM, FOLD1, FOLD2, OUT}.
- One sub-module, gf2m409_fold: combinational single fold step (acc_in ACC_W -> acc_out ACC_W). It is instantiated once and reused in both fold states via state mux.

Test Plan:
1. Single product (0,0), pp_data=1, pp_last=1 -> res_valid 3 cycles later, res_data=1, pp_dup_err=0.
2. (i,j)=(1,2), pp_data bit100 set (x^409), last -> res_data bits 0 and 87 set only.
3. (3,3), pp_data bit202 set (x^820), last -> res_data bits 2 and 176 set only (x^89 cancels across folds).
4. All 16 products of a=x^408, b=1, then random vectors vs. golden carry-less multiply+reduce model -> exact match.
5. (0,0) data=5 twice, second with last -> res_data=0, pp_dup_err=1 and stays 1 through next multiply.
6. res_ready low 5 cycles in OUT -> res_data stable, pp_ready=0; then rst_n pulse mid-ACCUM of next op -> res_valid=0, next single product (0,0)=3 yields res_data=3.

Source files
------------

// File: rtl/gf2m409_pkg.sv
// Shared constants and state encoding for the GF(2^409) product
// accumulate/reduce block.
package gf2m409_pkg;
   localparam int M     = 409;
   localparam int D     = 103;
   localparam int ND    = 4;
   localparam int K     = 87;
   localparam int PW    = 2 * D - 1;
   localparam int ACC_W = 2 * (ND - 1) * D + 2 * D - 1;

   typedef enum logic [1:0] {
      ACCUM,
      FOLD1,
      FOLD2,
      OUT
   } state_e;
endpackage

// File: rtl/gf2m409_fold.sv
// One reduction step modulo x^409 + x^87 + 1: bits at and above
// x^409 are folded back as hi + hi*x^87.
module gf2m409_fold
   import gf2m409_pkg::*;
(
   input  logic [ACC_W-1:0] acc_in,
   output logic [ACC_W-1:0] acc_out
);

   logic [ACC_W-1:0] lo;
   logic [ACC_W-1:0] hi;

   assign lo      = ACC_W'(acc_in[M-1:0]);
   assign hi      = ACC_W'(acc_in[ACC_W-1:M]);
   assign acc_out = lo ^ hi ^ (hi << K);

endmodule

// File: rtl/gf2m409_pp_accum_reduce.sv
// Accumulates 16 digit-pair carry-less products and reduces the
// 823-bit sum to a GF(2^409) element in two fold cycles.
module gf2m409_pp_accum_reduce
   import gf2m409_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pp_valid,
   output logic          pp_ready,
   input  logic [PW-1:0] pp_data,
   input  logic [1:0]    pp_idx_i,
   input  logic [1:0]    pp_idx_j,
   input  logic          pp_last,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [M-1:0]  res_data,
   output logic          busy,
   output logic          pp_dup_err
);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [15:0]      seen_q, seen_d;
   logic [M-1:0]     res_q, res_d;
   logic             rv_q, rv_d;
   logic             dup_q, dup_d;

   logic [ACC_W-1:0] fold_out;
   logic [ACC_W-1:0] pp_sh;
   logic [9:0]       sh_amt;
   logic [3:0]       idx;

   gf2m409_fold u_fold (
      .acc_in  (acc_q),
      .acc_out (fold_out)
   );

   // Digit offset is 103*(i+j); i+j ranges 0..6.
   assign sh_amt = 10'(D) * (10'(pp_idx_i) + 10'(pp_idx_j));
   assign pp_sh  = ACC_W'(pp_data) << sh_amt;
   assign idx    = {pp_idx_i, pp_idx_j};

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      seen_d   = seen_q;
      res_d    = res_q;
      rv_d     = rv_q;
      dup_d    = dup_q;
      pp_ready = 1'b0;
      unique case (state_q)
         ACCUM: begin
            pp_ready = 1'b1;
            if (pp_valid) begin
               acc_d       = acc_q ^ pp_sh;
               seen_d[idx] = 1'b1;
               if (seen_q[idx]) dup_d = 1'b1;
               if (pp_last) state_d = FOLD1;
            end
         end
         FOLD1: begin
            acc_d   = fold_out;
            state_d = FOLD2;
         end
         FOLD2: begin
            acc_d   = fold_out;
            res_d   = fold_out[M-1:0];
            state_d = OUT;
         end
         OUT: begin
            // First OUT cycle raises valid; handshake completes later.
            if (!rv_q) begin
               rv_d = 1'b1;
            end else if (res_ready) begin
               rv_d    = 1'b0;
               acc_d   = '0;
               seen_d  = '0;
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         seen_q  <= '0;
         res_q   <= '0;
         rv_q    <= 1'b0;
         dup_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         seen_q  <= seen_d;
         res_q   <= res_d;
         rv_q    <= rv_d;
         dup_q   <= dup_d;
      end
   end

   assign res_valid  = rv_q;
   assign res_data   = res_q;
   assign pp_dup_err = dup_q;
   assign busy       = (state_q != ACCUM) || (|acc_q);

endmodule
